// File: rtl/mux_scan_ctrl.sv
// Channel-scan sequencer for a 4:1 bit mux: steps sel over enabled channels,
// settles, samples dout and packs the four samples into a strobed word.
module mux_scan_ctrl #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic [3:0] ch_mask,
    input  logic       mux_dout,
    output logic [2:0] mux_sel,
    output logic       busy,
    output logic [3:0] word,
    output logic       word_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       mask_q;
    logic [1:0]       ch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       buf_q;
    logic [3:0]       word_q;
    logic             valid_q;

    logic [3:0]       hi_mask;
    logic             has_next;
    logic             settle_done;
    logic             launch;
    logic             relaunch;

    function automatic logic [1:0] low_ch(input logic [3:0] m);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) c = 2'(i);
        end
        return c;
    endfunction

    // Enabled channels strictly above the current one.
    assign hi_mask     = mask_q & (4'b1110 << ch_q);
    assign has_next    = |hi_mask;
    assign settle_done = (cnt_q == CNT_W'(SETTLE - 1));
    assign launch      = (state_q == S_IDLE) && start && (|ch_mask);
    assign relaunch    = (state_q == S_DONE) && continuous && (|ch_mask);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (launch) state_d = S_SETTLE;
            S_SETTLE: if (settle_done) state_d = S_SAMPLE;
            S_SAMPLE: state_d = has_next ? S_SETTLE : S_DONE;
            S_DONE:   state_d = relaunch ? S_SETTLE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        mux_sel = 3'd0;
        if (state_q == S_SETTLE || state_q == S_SAMPLE) begin
            mux_sel = {1'b0, ch_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= 4'd0;
            ch_q    <= 2'd0;
            cnt_q   <= '0;
            buf_q   <= 4'd0;
            word_q  <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        mask_q <= ch_mask;
                        buf_q  <= 4'd0;
                        ch_q   <= low_ch(ch_mask);
                        cnt_q  <= '0;
                    end
                end
                S_SETTLE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_SAMPLE: begin
                    buf_q[ch_q] <= mux_dout;
                    cnt_q       <= '0;
                    if (has_next) ch_q <= low_ch(hi_mask);
                end
                S_DONE: begin
                    word_q  <= buf_q & mask_q;
                    valid_q <= 1'b1;
                    if (continuous) begin
                        mask_q <= ch_mask;
                        if (|ch_mask) begin
                            buf_q <= 4'd0;
                            ch_q  <= low_ch(ch_mask);
                            cnt_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a 4:1 mux model and a word scoreboard.
module tb_mux_scan_ctrl;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       continuous;
    logic [3:0] ch_mask;
    logic       mux_dout;
    logic [2:0] mux_sel;
    logic       busy;
    logic [3:0] word;
    logic       word_valid;
    logic [3:0] din;

    typedef struct {
        logic [3:0] w;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] sel_log[$];
    int         cyc     = 0;
    int         strobes = 0;
    int         n_cmp   = 0;
    int         n_bad   = 0;

    mux_scan_ctrl #(.SETTLE(SETTLE), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .continuous(continuous),
        .ch_mask   (ch_mask),
        .mux_dout  (mux_dout),
        .mux_sel   (mux_sel),
        .busy      (busy),
        .word      (word),
        .word_valid(word_valid)
    );

    // 4:1 mux model; only sel[1:0] selects, sel[2] is expected to stay 0.
    assign mux_dout = din[mux_sel[1:0]];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) sel_log.push_back(mux_sel);
        if (word_valid) begin
            strobes++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(word_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("word", 32'(word), 32'(e.w));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    // Drive one start pulse; returns the cycle stamp at which the strobe is due.
    task automatic scan(input logic [3:0] m, input logic [3:0] d,
                        input logic cont, output int due);
        int lat;
        lat        = 1 + $countones(m) * (SETTLE + 1);
        ch_mask    = m;
        din        = d;
        continuous = cont;
        start      = 1'b1;
        due        = cyc + 1 + lat;
        sb.push_back('{d & m, due});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int t;
        int s0;
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        ch_mask    = 4'd0;
        din        = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state held while idle.
        repeat (5) begin
            @(negedge clk);
            chk("rst_sel", 32'(mux_sel), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_word", 32'(word), 0);
            chk("rst_valid", 32'(word_valid), 0);
        end

        // Full mask: each channel held SETTLE+1 cycles, then DONE at sel 0.
        sel_log.delete();
        scan(4'b1111, 4'b1010, 1'b0, t);
        drain();
        chk("t2_nsel", sel_log.size(), 13);
        for (int i = 0; i < 13; i++) begin
            chk("t2_sel", 32'(sel_log[i]), (i < 12) ? i / 3 : 0);
        end
        chk("t2_idle", 32'(busy), 0);

        // Sparse mask: masked channels never reach mux_sel.
        sel_log.delete();
        scan(4'b0101, 4'b1111, 1'b0, t);
        drain();
        chk("t3_nsel", sel_log.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk("t3_sel", 32'(sel_log[i]), (i >= 3 && i < 6) ? 2 : 0);
        end

        // Continuous: back-to-back words, input change between scans.
        s0 = strobes;
        scan(4'b1111, 4'b0011, 1'b1, t);
        sb.push_back('{4'b1100, t + 13});
        while (cyc < t + 1) @(negedge clk);
        din = 4'b1100;
        repeat (3) @(negedge clk);
        continuous = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("t4_strobes", strobes - s0, 2);
        chk("t4_idle", 32'(busy), 0);

        // Reset during SETTLE of channel 2 discards the scan.
        s0         = strobes;
        ch_mask    = 4'b1111;
        din        = 4'b1111;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_pre_sel", 32'(mux_sel), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_sel", 32'(mux_sel), 0);
        chk("t5_valid", 32'(word_valid), 0);
        chk("t5_word", 32'(word), 0);
        repeat (15) @(negedge clk);
        chk("t5_nostrobe", strobes - s0, 0);
        scan(4'b1111, 4'b0110, 1'b0, t);
        drain();

        // Empty mask is ignored; start while busy does not queue a scan.
        ch_mask = 4'b0000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n = n + (busy ? 1 : 0);
        end
        chk("t6_empty_busy", n, 0);
        s0 = strobes;
        scan(4'b0011, 4'b1111, 1'b0, t);
        repeat (2) @(negedge clk);
        ch_mask = 4'b1111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("t6_strobes", strobes - s0, 1);
        chk("t6_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
